// File: rtl/layer_compositor.sv
// layer_compositor: merges NUM_LAYERS colour-keyed sprite layers into one VGA
// pixel through a runtime-programmable priority table, and accumulates
// per-frame collision / off-road flags for the collider layer.
// Two-stage pipeline: stage 1 captures opacity and pixels, stage 2 resolves
// the priority mux. The priority table is double-buffered and committed
// when the first pixel of a frame reaches stage 2.
module layer_compositor #(
    parameter int                 NUM_LAYERS    = 8,
    parameter int                 COLOR_W       = 8,
    parameter logic [COLOR_W-1:0] MASK_VALUE    = 8'h62,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 8'h76,
    parameter int                 COLLIDER      = 0,
    parameter int                 X_MIN         = 166,
    parameter int                 X_MAX         = 414,
    parameter int                 IDX_W         = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_of_frame,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixels,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [10:0]                   pixel_x,
    input  logic                          prio_wr_en,
    input  logic [IDX_W-1:0]              prio_wr_rank,
    input  logic [IDX_W-1:0]              prio_wr_layer,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic [NUM_LAYERS-1:0]         hit_live,
    output logic [NUM_LAYERS-1:0]         collision_flags,
    output logic                          off_road_flag
);

    localparam logic [10:0] X_MIN_L = 11'(X_MIN);
    localparam logic [10:0] X_MAX_L = 11'(X_MAX);

    logic [COLOR_W-1:0]    s1_pix_q    [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] s1_opaque_q;
    logic                  s1_off_q;
    logic                  s1_sof_q;
    logic                  s1_valid_q;

    logic [IDX_W-1:0]      shadow_q    [NUM_LAYERS];
    logic [IDX_W-1:0]      shadow_d    [NUM_LAYERS];
    logic [IDX_W-1:0]      active_q    [NUM_LAYERS];
    logic [IDX_W-1:0]      tbl_use     [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] opaque_in;
    logic                  off_in;
    logic [NUM_LAYERS-1:0] hit_s1;
    logic [COLOR_W-1:0]    rgb_d;
    logic [NUM_LAYERS-1:0] acc_q;
    logic                  off_acc_q;

    // Opacity of each incoming layer and the collider's road-edge test.
    always_comb begin
        opaque_in = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque_in[i] = layer_enable[i] &&
                           (layer_pixels[i*COLOR_W +: COLOR_W] != MASK_VALUE);
        end
        off_in = opaque_in[COLLIDER] && ((pixel_x <= X_MIN_L) || (pixel_x >= X_MAX_L));
    end

    // Stage 1: capture pixels, opacity, off-road compare and frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_opaque_q <= '0;
            s1_off_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) s1_pix_q[i] <= '0;
        end else begin
            s1_opaque_q <= opaque_in;
            s1_off_q    <= off_in;
            s1_sof_q    <= start_of_frame;
            s1_valid_q  <= 1'b1;
            for (int i = 0; i < NUM_LAYERS; i++) s1_pix_q[i] <= layer_pixels[i*COLOR_W +: COLOR_W];
        end
    end

    // Shadow table update; out-of-range writes are dropped. The commit table is
    // the post-write shadow so a write landing on the commit cycle takes effect.
    always_comb begin
        for (int r = 0; r < NUM_LAYERS; r++) shadow_d[r] = shadow_q[r];
        if (prio_wr_en && (32'(prio_wr_rank) < NUM_LAYERS) && (32'(prio_wr_layer) < NUM_LAYERS)) begin
            shadow_d[prio_wr_rank] = prio_wr_layer;
        end
        for (int r = 0; r < NUM_LAYERS; r++) tbl_use[r] = s1_sof_q ? shadow_d[r] : active_q[r];
    end

    // Stage 2 priority mux (rank 0 wins) and collider overlap vector.
    always_comb begin
        rgb_d = DEFAULT_COLOR;
        for (int r = NUM_LAYERS - 1; r >= 0; r--) begin
            if (s1_opaque_q[tbl_use[r]]) rgb_d = s1_pix_q[tbl_use[r]];
        end
        hit_s1 = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i != COLLIDER) hit_s1[i] = s1_opaque_q[COLLIDER] && s1_opaque_q[i];
        end
    end

    // Stage 2 registers, table commit and per-frame flag accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out         <= '0;
            hit_live        <= '0;
            collision_flags <= '0;
            off_road_flag   <= 1'b0;
            acc_q           <= '0;
            off_acc_q       <= 1'b0;
            for (int r = 0; r < NUM_LAYERS; r++) begin
                shadow_q[r] <= IDX_W'(r);
                active_q[r] <= IDX_W'(r);
            end
        end else begin
            for (int r = 0; r < NUM_LAYERS; r++) begin
                shadow_q[r] <= shadow_d[r];
                if (s1_sof_q) active_q[r] <= shadow_d[r];
            end
            if (s1_valid_q) begin
                rgb_out  <= rgb_d;
                hit_live <= hit_s1;
            end
            if (s1_sof_q) begin
                collision_flags <= acc_q;
                off_road_flag   <= off_acc_q;
                acc_q           <= hit_s1;
                off_acc_q       <= s1_off_q;
            end else begin
                acc_q     <= acc_q | hit_s1;
                off_acc_q <= off_acc_q | s1_off_q;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: a directed frame sequence plus random frames,
// every output compared each cycle against a frame-level reference model.
module tb_layer_compositor;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int MAXS = 1024;
    localparam logic [7:0] MASK = 8'h62;
    localparam logic [7:0] DEFC = 8'h76;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_of_frame;
    logic [N*W-1:0] layer_pixels;
    logic [N-1:0]   layer_enable;
    logic [10:0]    pixel_x;
    logic           prio_wr_en;
    logic [2:0]     prio_wr_rank;
    logic [2:0]     prio_wr_layer;
    logic [W-1:0]   rgb_out;
    logic [N-1:0]   hit_live;
    logic [N-1:0]   collision_flags;
    logic           off_road_flag;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk             (clk),
        .reset           (reset),
        .start_of_frame  (start_of_frame),
        .layer_pixels    (layer_pixels),
        .layer_enable    (layer_enable),
        .pixel_x         (pixel_x),
        .prio_wr_en      (prio_wr_en),
        .prio_wr_rank    (prio_wr_rank),
        .prio_wr_layer   (prio_wr_layer),
        .rgb_out         (rgb_out),
        .hit_live        (hit_live),
        .collision_flags (collision_flags),
        .off_road_flag   (off_road_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-segment stimulus record (a segment starts at a reset release).
    logic [7:0] s_pix [MAXS][N];
    logic [7:0] s_en  [MAXS];
    int         s_x   [MAXS];
    bit         s_sof [MAXS];
    bit         s_we  [MAXS];
    int         s_rank[MAXS];
    int         s_lay [MAXS];
    int         nsamp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit opq(int s, int l);
        return s_en[s][l] && (s_pix[s][l] != MASK);
    endfunction

    function automatic logic [7:0] m_hits(int s);
        logic [7:0] h = '0;
        for (int i = 1; i < N; i++) h[i] = opq(s, 0) && opq(s, i);
        return h;
    endfunction

    function automatic bit m_off(int s);
        return opq(s, 0) && (s_x[s] <= 166 || s_x[s] >= 414);
    endfunction

    function automatic int last_sof(int s);
        int j = -1;
        for (int k = 0; k <= s; k++) if (s_sof[k]) j = k;
        return j;
    endfunction

    // Frame table = all writes up to and including the cycle after its first pixel.
    function automatic logic [7:0] m_rgb(int s);
        int tbl[N];
        int j;
        for (int r = 0; r < N; r++) tbl[r] = r;
        j = last_sof(s);
        if (j >= 0) begin
            for (int k = 0; k <= j + 1; k++) begin
                if (s_we[k] && s_rank[k] < N && s_lay[k] < N) tbl[s_rank[k]] = s_lay[k];
            end
        end
        for (int r = 0; r < N; r++) begin
            if (opq(s, tbl[r])) return s_pix[s][tbl[r]];
        end
        return DEFC;
    endfunction

    // Flags shown during frame j are the OR over the preceding frame's pixels.
    function automatic logic [8:0] m_flags(int s);
        int j = -1;
        int p = 0;
        logic [8:0] f = '0;
        for (int k = 0; k <= s; k++) begin
            if (s_sof[k]) begin
                p = (j >= 0) ? j : 0;
                j = k;
            end
        end
        if (j < 0) return '0;
        for (int k = p; k < j; k++) begin
            f[7:0] = f[7:0] | m_hits(k);
            f[8]   = f[8] | m_off(k);
        end
        return f;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_seg();
        nsamp = 0;
        for (int k = 0; k < MAXS; k++) begin
            s_sof[k] = 0; s_we[k] = 0; s_en[k] = '0; s_x[k] = 0;
            s_rank[k] = 0; s_lay[k] = 0;
            for (int l = 0; l < N; l++) s_pix[k][l] = MASK;
        end
    endtask

    task automatic add(input logic [N*W-1:0] pixv, input logic [7:0] en, input int x,
                       input bit sof, input bit we, input int rank, input int lay);
        for (int l = 0; l < N; l++) s_pix[nsamp][l] = pixv[l*W +: W];
        s_en[nsamp]   = en;
        s_x[nsamp]    = x;
        s_sof[nsamp]  = sof;
        s_we[nsamp]   = we;
        s_rank[nsamp] = rank;
        s_lay[nsamp]  = lay;
        nsamp++;
    endtask

    task automatic add_px(input logic [N*W-1:0] pixv, input int x, input bit sof, input int reps);
        for (int k = 0; k < reps; k++) add(pixv, 8'hFF, x, sof, 1'b0, 0, 0);
    endtask

    task automatic fill_random(input int count);
        logic [N*W-1:0] pv;
        int sel;
        for (int k = 0; k < count; k++) begin
            for (int l = 0; l < N; l++) pv[l*W +: W] = ($urandom_range(0, 1) == 0) ? MASK : 8'($urandom);
            sel = $urandom_range(0, 5);
            add(pv, 8'($urandom | $urandom | $urandom),
                (sel == 0) ? 166 : (sel == 1) ? 167 : (sel == 2) ? 413 : (sel == 3) ? 414 : $urandom_range(0, 799),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
                $urandom_range(0, N - 1), $urandom_range(0, N - 1));
        end
        s_sof[count / 3]     = 1;
        s_sof[count / 3 + 1] = 1;
    endtask

    task automatic drive_idle();
        start_of_frame = 0;
        layer_pixels   = {N{MASK}};
        layer_enable   = '0;
        pixel_x        = '0;
        prio_wr_en     = 0;
        prio_wr_rank   = '0;
        prio_wr_layer  = '0;
    endtask

    task automatic drive_sample(input int t);
        for (int l = 0; l < N; l++) layer_pixels[l*W +: W] = s_pix[t][l];
        layer_enable   = s_en[t];
        pixel_x        = 11'(s_x[t]);
        start_of_frame = s_sof[t];
        prio_wr_en     = s_we[t];
        prio_wr_rank   = 3'(s_rank[t]);
        prio_wr_layer  = 3'(s_lay[t]);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rgb",   32'(rgb_out), 32'h0);
        check_val("rst_hit",   32'(hit_live), 32'h0);
        check_val("rst_flags", 32'(collision_flags), 32'h0);
        check_val("rst_off",   32'(off_road_flag), 32'h0);
    endtask

    // Releases reset on the first negedge, then plays the segment and checks
    // every output two cycles after each sample.
    task automatic run_seg();
        logic [8:0] f;
        for (int t = 0; t < nsamp + 2; t++) begin
            @(negedge clk);
            reset = 0;
            if (t >= 2) begin
                f = m_flags(t - 2);
                check_val("rgb_out",         32'(rgb_out), 32'(m_rgb(t - 2)));
                check_val("hit_live",        32'(hit_live), 32'(m_hits(t - 2)));
                check_val("collision_flags", 32'(collision_flags), 32'(f[7:0]));
                check_val("off_road_flag",   32'(off_road_flag), 32'(f[8]));
            end
            if (t < nsamp) drive_sample(t);
            else drive_idle();
        end
    endtask

    logic [N*W-1:0] v_all_mask, v1, vc, vo;

    initial begin
        reset = 1;
        drive_idle();
        repeat (2) @(negedge clk);
        check_reset_outputs();

        v_all_mask = {N{MASK}};
        v1 = v_all_mask;  v1[1*W +: W] = 8'h1C;  v1[3*W +: W] = 8'hE0;
        vc = v_all_mask;  vc[0 +: W]   = 8'h03;  vc[2*W +: W] = 8'h40;
        vo = v_all_mask;  vo[0 +: W]   = 8'h03;

        // Directed segment following the frame-level scenarios.
        clear_seg();
        add_px(v_all_mask, 300, 0, 4);
        add_px(v1, 300, 0, 3);
        for (int k = 0; k < 2; k++) add(v1, 8'hFD, 300, 0, 0, 0, 0);
        add(v1, 8'hFF, 300, 0, 1, 0, 3);
        add_px(v1, 300, 0, 3);
        add_px(v1, 300, 1, 1);
        add_px(v1, 300, 0, 2);
        add_px(vc, 200, 0, 1);
        add_px(v1, 200, 0, 3);
        add_px(v1, 200, 1, 1);
        add_px(v1, 200, 0, 4);
        add_px(v1, 200, 1, 1);
        add_px(v1, 200, 0, 2);
        add_px(vo, 166, 0, 1);
        add_px(v1, 300, 0, 2);
        add_px(v1, 300, 1, 1);
        add_px(vo, 414, 0, 1);
        add_px(v1, 300, 0, 1);
        add_px(v1, 300, 1, 1);
        add_px(vo, 167, 0, 1);
        add_px(vo, 413, 0, 1);
        add_px(v1, 300, 0, 1);
        add_px(v1, 300, 1, 1);
        add_px(v1, 300, 0, 3);
        add_px(vc, 200, 1, 1);
        add_px(v1, 200, 0, 3);
        add_px(v1, 200, 1, 1);
        add_px(v1, 200, 0, 3);
        add_px(v1, 300, 1, 1);
        add(v1, 8'hFF, 300, 0, 1, 0, 1);
        add_px(v1, 300, 0, 2);
        add_px(v1, 300, 1, 1);
        add_px(v1, 300, 1, 1);
        add_px(v1, 300, 0, 3);
        run_seg();

        // Random segment, then a reset in the middle of a frame.
        reset = 1;
        drive_idle();
        @(negedge clk);
        clear_seg();
        fill_random(600);
        run_seg();
        reset = 1;
        drive_idle();
        @(negedge clk);
        check_reset_outputs();

        // Fresh segment after the mid-frame reset: model restarts from identity.
        clear_seg();
        fill_random(600);
        run_seg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
